// File: rtl/block_ctrl_unit.sv
// ID-stage control unit: registered decode of data-processing, load/store and branch
// instructions, plus block-transfer sequencing with freeze and flush handling.
module block_ctrl_unit #(
   parameter int NREG  = 16,
   parameter int IDX_W = $clog2(NREG),
   parameter int OFF_W = IDX_W + 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       mode,
   input  logic [3:0]       op_code,
   input  logic             s_in,
   input  logic [NREG-1:0]  reg_list,
   input  logic             freeze,
   input  logic             flush,
   output logic             valid_out,
   output logic [3:0]       exe_cmd,
   output logic             mem_read,
   output logic             mem_write,
   output logic             wb_en,
   output logic             s_out,
   output logic             b_out,
   output logic [IDX_W-1:0] reg_idx,
   output logic [OFF_W-1:0] mem_offset,
   output logic             last_beat
);

   typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

   localparam logic [NREG-1:0] LIST_ONE = NREG'(1);
   localparam logic [IDX_W:0]  CNT_ONE  = (IDX_W + 1)'(1);

   state_t            st, st_nxt;
   logic [NREG-1:0]   pending, pending_nxt;
   logic [IDX_W:0]    beat_cnt, beat_cnt_nxt;
   logic              ld, ld_nxt;

   logic              valid_nxt, mr_nxt, mw_nxt, wb_nxt, s_nxt, b_nxt, last_nxt;
   logic [3:0]        exe_nxt;
   logic [IDX_W-1:0]  idx_nxt;
   logic [OFF_W-1:0]  off_nxt;

   logic [IDX_W-1:0]  list_idx, pend_idx;
   logic [NREG-1:0]   list_rest, pend_rest;

   // Descending scan so the final assignment wins with the lowest set bit.
   function automatic logic [IDX_W-1:0] lsb_idx(input logic [NREG-1:0] m);
      logic [IDX_W-1:0] r;
      r = '0;
      for (int unsigned i = NREG; i > 0; i--) begin
         if (m[i-1]) r = IDX_W'(i - 1);
      end
      return r;
   endfunction

   assign in_ready = !freeze && (pending == '0);

   assign list_idx  = lsb_idx(reg_list);
   assign list_rest = reg_list & (reg_list - LIST_ONE);
   assign pend_idx  = lsb_idx(pending);
   assign pend_rest = pending & (pending - LIST_ONE);

   always_comb begin
      pending_nxt  = pending;
      beat_cnt_nxt = beat_cnt;
      ld_nxt       = ld;
      valid_nxt    = valid_out;
      exe_nxt      = exe_cmd;
      mr_nxt       = mem_read;
      mw_nxt       = mem_write;
      wb_nxt       = wb_en;
      s_nxt        = s_out;
      b_nxt        = b_out;
      idx_nxt      = reg_idx;
      off_nxt      = mem_offset;
      last_nxt     = last_beat;

      // Flush or any unfrozen cycle starts from an all-zero output set.
      if (flush || !freeze) begin
         pending_nxt  = '0;
         beat_cnt_nxt = '0;
         valid_nxt    = 1'b0;
         exe_nxt      = '0;
         mr_nxt       = 1'b0;
         mw_nxt       = 1'b0;
         wb_nxt       = 1'b0;
         s_nxt        = 1'b0;
         b_nxt        = 1'b0;
         idx_nxt      = '0;
         off_nxt      = '0;
         last_nxt     = 1'b0;
      end

      if (!flush && !freeze) begin
         case (st)
            XFER: begin
               pending_nxt  = pend_rest;
               beat_cnt_nxt = beat_cnt + CNT_ONE;
               valid_nxt    = 1'b1;
               exe_nxt      = 4'b0010;
               mr_nxt       = ld;
               wb_nxt       = ld;
               mw_nxt       = !ld;
               idx_nxt      = pend_idx;
               off_nxt      = {beat_cnt_nxt[IDX_W-1:0], 2'b00};
               last_nxt     = (pend_rest == '0);
            end
            default: begin
               if (in_valid && in_ready) begin
                  valid_nxt = 1'b1;
                  last_nxt  = 1'b1;
                  case (mode)
                     2'b00: begin
                        case (op_code)
                           4'b1101: begin exe_nxt = 4'b0001; wb_nxt = 1'b1; s_nxt = s_in; end
                           4'b1111: begin exe_nxt = 4'b1001; wb_nxt = 1'b1; s_nxt = s_in; end
                           4'b0100: begin exe_nxt = 4'b0010; wb_nxt = 1'b1; s_nxt = s_in; end
                           4'b0101: begin exe_nxt = 4'b0011; wb_nxt = 1'b1; s_nxt = s_in; end
                           4'b0010: begin exe_nxt = 4'b0100; wb_nxt = 1'b1; s_nxt = s_in; end
                           4'b0110: begin exe_nxt = 4'b0101; wb_nxt = 1'b1; s_nxt = s_in; end
                           4'b0000: begin exe_nxt = 4'b0110; wb_nxt = 1'b1; s_nxt = s_in; end
                           4'b1100: begin exe_nxt = 4'b0111; wb_nxt = 1'b1; s_nxt = s_in; end
                           4'b0001: begin exe_nxt = 4'b1000; wb_nxt = 1'b1; s_nxt = s_in; end
                           4'b1010: begin exe_nxt = 4'b0100; s_nxt = 1'b1; end
                           4'b1000: begin exe_nxt = 4'b0110; s_nxt = 1'b1; end
                           default: ;
                        endcase
                     end
                     2'b01: begin
                        exe_nxt = 4'b0010;
                        mr_nxt  = s_in;
                        wb_nxt  = s_in;
                        mw_nxt  = !s_in;
                     end
                     2'b10: begin
                        exe_nxt = 4'b0000;
                        b_nxt   = 1'b1;
                        s_nxt   = s_in;
                     end
                     default: begin
                        exe_nxt = 4'b0010;
                        ld_nxt  = s_in;
                        // An empty list still yields one strobe-free beat.
                        if (reg_list != '0) begin
                           mr_nxt      = s_in;
                           wb_nxt      = s_in;
                           mw_nxt      = !s_in;
                           idx_nxt     = list_idx;
                           pending_nxt = list_rest;
                           last_nxt    = (list_rest == '0);
                        end
                     end
                  endcase
               end
            end
         endcase
      end

      st_nxt = (pending_nxt == '0) ? IDLE : XFER;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st         <= IDLE;
         pending    <= '0;
         beat_cnt   <= '0;
         ld         <= 1'b0;
         valid_out  <= 1'b0;
         exe_cmd    <= '0;
         mem_read   <= 1'b0;
         mem_write  <= 1'b0;
         wb_en      <= 1'b0;
         s_out      <= 1'b0;
         b_out      <= 1'b0;
         reg_idx    <= '0;
         mem_offset <= '0;
         last_beat  <= 1'b0;
      end else begin
         st         <= st_nxt;
         pending    <= pending_nxt;
         beat_cnt   <= beat_cnt_nxt;
         ld         <= ld_nxt;
         valid_out  <= valid_nxt;
         exe_cmd    <= exe_nxt;
         mem_read   <= mr_nxt;
         mem_write  <= mw_nxt;
         wb_en      <= wb_nxt;
         s_out      <= s_nxt;
         b_out      <= b_nxt;
         reg_idx    <= idx_nxt;
         mem_offset <= off_nxt;
         last_beat  <= last_nxt;
      end
   end

endmodule
